// File: rtl/mac_job_sequencer.sv
// Sequences one super_mac array through a num_terms dot-product job; operands are taken with valid/ready.
// Result appears P_DELAY+ACC_DELAY cycles after the last operand fire and is held until out_ready.
module mac_job_sequencer #(
  parameter int CNT_WIDTH = 16,
  parameter int P_DELAY   = 1,
  parameter int ACC_DELAY = 1
) (
  input  logic                 clk,
  input  logic                 arst_n_in,
  input  logic                 start,
  input  logic [CNT_WIDTH-1:0] num_terms,
  input  logic                 clear,
  output logic                 busy,
  output logic                 cfg_err,
  input  logic                 op_valid,
  output logic                 op_ready,
  output logic [CNT_WIDTH-1:0] term_index,
  output logic                 mac_input_valid,
  output logic                 mac_p_valid,
  output logic                 mac_accumulate_internal,
  output logic                 out_valid,
  input  logic                 out_ready
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, RESULT} state_t;

  localparam int DCW = 3;
  localparam logic [DCW-1:0]       DRAIN_LOAD = DCW'(P_DELAY + ACC_DELAY - 2);
  localparam logic [CNT_WIDTH-1:0] ONE        = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_t               state, state_nxt;
  logic [CNT_WIDTH-1:0] num_lat;
  logic [DCW-1:0]       drain_cnt;
  logic [P_DELAY-1:0]   fire_pipe, first_pipe;
  logic [P_DELAY:0]     fire_sr, first_sr;
  logic                 fire, last_fire, accept;

  assign busy      = (state != IDLE);
  assign op_ready  = (state == RUN);
  assign out_valid = (state == RESULT);

  assign fire            = op_valid & op_ready;
  assign mac_input_valid = fire;
  assign last_fire       = fire && (term_index == num_lat - ONE);
  assign accept          = (state == IDLE) && start && (num_terms != '0);

  // The first flag rides alongside fire so the array loads on term 0 and adds afterwards.
  assign fire_sr  = {fire_pipe, fire};
  assign first_sr = {first_pipe, (term_index == '0)};

  assign mac_p_valid             = fire_pipe[P_DELAY-1];
  assign mac_accumulate_internal = fire_pipe[P_DELAY-1] & ~first_pipe[P_DELAY-1];

  always_ff @(posedge clk) begin
    if (!arst_n_in || clear) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (last_fire) state_nxt = DRAIN;
      DRAIN:   if (drain_cnt == '0) state_nxt = RESULT;
      RESULT:  if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!arst_n_in || clear) begin
      num_lat    <= '0;
      term_index <= '0;
      drain_cnt  <= '0;
      fire_pipe  <= '0;
      first_pipe <= '0;
      cfg_err    <= 1'b0;
    end else begin
      cfg_err    <= (state == IDLE) && start && (num_terms == '0);
      fire_pipe  <= fire_sr[P_DELAY-1:0];
      first_pipe <= first_sr[P_DELAY-1:0];
      if (accept) begin
        num_lat    <= num_terms;
        term_index <= '0;
      end else if (fire) begin
        term_index <= term_index + ONE;
      end
      // Drain covers the remaining multiplier stages plus the accumulator settle time.
      if (last_fire) begin
        drain_cnt <= DRAIN_LOAD;
      end else if ((state == DRAIN) && (drain_cnt != '0)) begin
        drain_cnt <= drain_cnt - DCW'(1);
      end
    end
  end

endmodule

// File: tb/tb_mac_job_sequencer.sv
// Bench for mac_job_sequencer: vector table, multi-cycle sequences, and randomized traffic against an event model.
module tb_mac_job_sequencer;
  localparam int CW = 16;
  localparam int PD = 1;
  localparam int AD = 1;

  logic          clk = 1'b0;
  logic          arst_n_in, start, clear, op_valid, out_ready;
  logic [CW-1:0] num_terms;
  logic          busy, cfg_err, op_ready, mac_input_valid, mac_p_valid;
  logic          mac_accumulate_internal, out_valid;
  logic [CW-1:0] term_index;

  mac_job_sequencer #(.CNT_WIDTH(CW), .P_DELAY(PD), .ACC_DELAY(AD)) dut (
    .clk(clk), .arst_n_in(arst_n_in), .start(start), .num_terms(num_terms), .clear(clear),
    .busy(busy), .cfg_err(cfg_err), .op_valid(op_valid), .op_ready(op_ready),
    .term_index(term_index), .mac_input_valid(mac_input_valid), .mac_p_valid(mac_p_valid),
    .mac_accumulate_internal(mac_accumulate_internal), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  // o = {busy, cfg_err, op_ready, mac_input_valid, mac_p_valid, mac_accumulate_internal, out_valid}
  logic [6:0]    o;
  logic [CW-1:0] o_ti;

  // Job-level reference model: counts of issued terms and a queue of scheduled products.
  typedef struct { int c; bit acc; } pev_t;
  pev_t pq[$];
  bit   m_active = 1'b0;
  int   m_n = 0, m_issued = 0, m_last = -100, m_rej = -100;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, got, exp);
    end
  endtask

  task automatic model_cycle(input logic s, input logic [CW-1:0] n, input logic ov,
                             input logic cl, input logic rd, input logic rs);
    bit e_busy, e_cfg, e_ordy, e_miv, e_pv, e_acc, e_ov;
    e_busy = m_active;
    e_cfg  = (m_rej == cyc - 1);
    e_ordy = m_active && (m_issued < m_n);
    e_miv  = e_ordy && ov;
    e_pv   = (pq.size() != 0) && (pq[0].c == cyc);
    e_acc  = e_pv && pq[0].acc;
    e_ov   = m_active && (m_issued == m_n) && (cyc >= m_last + PD + AD);
    if (chk_en) begin
      chk("model.busy",     32'(o[6]), 32'(e_busy));
      chk("model.cfg_err",  32'(o[5]), 32'(e_cfg));
      chk("model.op_ready", 32'(o[4]), 32'(e_ordy));
      chk("model.in_valid", 32'(o[3]), 32'(e_miv));
      chk("model.p_valid",  32'(o[2]), 32'(e_pv));
      chk("model.acc_int",  32'(o[1]), 32'(e_acc));
      chk("model.out_valid",32'(o[0]), 32'(e_ov));
      chk("model.term_idx", 32'(o_ti), 32'(m_issued));
    end
    if (e_pv) void'(pq.pop_front());
    if (rs || cl) begin
      m_active = 1'b0;
      m_issued = 0;
      pq.delete();
    end else begin
      if (e_miv) begin
        pq.push_back('{c: cyc + PD, acc: (m_issued != 0)});
        m_issued++;
        m_last = cyc;
      end
      if (e_ov && rd) m_active = 1'b0;
      if (!e_busy && s) begin
        if (n != 0) begin
          m_active = 1'b1;
          m_issued = 0;
          m_n = int'(n);
        end else begin
          m_rej = cyc;
        end
      end
    end
  endtask

  task automatic step(input logic s, input logic [CW-1:0] n, input logic ov,
                      input logic cl, input logic rd, input logic rs);
    @(negedge clk);
    start = s; num_terms = n; op_valid = ov; clear = cl; out_ready = rd; arst_n_in = ~rs;
    #1;
    o = {busy, cfg_err, op_ready, mac_input_valid, mac_p_valid, mac_accumulate_internal, out_valid};
    o_ti = term_index;
    model_cycle(s, n, ov, cl, rd, rs);
    @(posedge clk);
    cyc++;
  endtask

  logic [31:0]   m_busy, m_ordy, m_pv, m_acc, m_ov;
  logic [CW-1:0] ti_at[32];

  task automatic run_seq(input logic [CW-1:0] n, input logic [31:0] st_m, input logic [31:0] opv_m,
                         input logic [31:0] clr_m, input logic [31:0] rd_m, input int len);
    m_busy = '0; m_ordy = '0; m_pv = '0; m_acc = '0; m_ov = '0;
    for (int c = 0; c < len; c++) begin
      step(st_m[c], n, opv_m[c], clr_m[c], rd_m[c], 1'b0);
      m_busy[c] = o[6]; m_ordy[c] = o[4]; m_pv[c] = o[2]; m_acc[c] = o[1]; m_ov[c] = o[0];
      ti_at[c] = o_ti;
    end
  endtask

  typedef struct {
    logic          s;
    logic [CW-1:0] n;
    logic          ov;
    logic          rd;
    logic [6:0]    e;
    logic [CW-1:0] eti;
  } vec_t;
  vec_t tbl[17];

  initial begin
    // basic job, num_terms=3
    tbl[0]  = '{1'b1, 16'd3, 1'b1, 1'b0, 7'b0000000, 16'd0};
    tbl[1]  = '{1'b0, 16'd3, 1'b1, 1'b0, 7'b1011000, 16'd0};
    tbl[2]  = '{1'b0, 16'd3, 1'b1, 1'b0, 7'b1011100, 16'd1};
    tbl[3]  = '{1'b0, 16'd3, 1'b1, 1'b0, 7'b1011110, 16'd2};
    tbl[4]  = '{1'b0, 16'd3, 1'b1, 1'b0, 7'b1000110, 16'd3};
    tbl[5]  = '{1'b0, 16'd3, 1'b1, 1'b0, 7'b1000001, 16'd3};
    tbl[6]  = '{1'b0, 16'd3, 1'b1, 1'b0, 7'b1000001, 16'd3};
    tbl[7]  = '{1'b0, 16'd3, 1'b1, 1'b1, 7'b1000001, 16'd3};
    tbl[8]  = '{1'b0, 16'd3, 1'b1, 1'b0, 7'b0000000, 16'd3};
    // single term
    tbl[9]  = '{1'b1, 16'd1, 1'b1, 1'b0, 7'b0000000, 16'd3};
    tbl[10] = '{1'b0, 16'd1, 1'b1, 1'b0, 7'b1011000, 16'd0};
    tbl[11] = '{1'b0, 16'd1, 1'b1, 1'b0, 7'b1000100, 16'd1};
    tbl[12] = '{1'b0, 16'd1, 1'b1, 1'b1, 7'b1000001, 16'd1};
    tbl[13] = '{1'b0, 16'd1, 1'b1, 1'b0, 7'b0000000, 16'd1};
    // rejected job
    tbl[14] = '{1'b1, 16'd0, 1'b1, 1'b0, 7'b0000000, 16'd1};
    tbl[15] = '{1'b0, 16'd0, 1'b1, 1'b0, 7'b0100000, 16'd1};
    tbl[16] = '{1'b0, 16'd0, 1'b1, 1'b0, 7'b0000000, 16'd1};

    start = 1'b0; num_terms = '0; op_valid = 1'b0; clear = 1'b0; out_ready = 1'b0; arst_n_in = 1'b0;
    step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk_en = 1'b1;
    step(1'b0, '0, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("reset.outputs", 32'(o), 32'(0));
    chk("reset.term_idx", 32'(o_ti), 32'(0));

    foreach (tbl[i]) begin
      step(tbl[i].s, tbl[i].n, tbl[i].ov, 1'b0, tbl[i].rd, 1'b0);
      chk($sformatf("tbl[%0d].outputs", i), 32'(o), 32'(tbl[i].e));
      chk($sformatf("tbl[%0d].term_idx", i), 32'(o_ti), 32'(tbl[i].eti));
    end

    // op_valid bubble in cycles 2-3
    run_seq(16'd3, 32'h1, 32'hFFFF_FFF3, 32'h0, 32'h100, 10);
    chk("bubble.p_valid", m_pv, 32'h64);
    chk("bubble.acc_int", m_acc, 32'h60);
    chk("bubble.out_valid", m_ov, 32'h180);
    chk("bubble.busy", m_busy, 32'h1FE);
    chk("bubble.op_ready", m_ordy, 32'h3E);

    // clear in cycle 3 of a 5-term job, restart in cycle 5
    run_seq(16'd5, 32'h21, 32'hFFFF_FFFF, 32'h8, 32'h2000, 14);
    chk("abort.p_valid", m_pv, 32'hF8C);
    chk("abort.acc_int", m_acc, 32'hF08);
    chk("abort.out_valid", m_ov, 32'h3000);
    chk("abort.busy", m_busy, 32'h3FCE);
    chk("abort.op_ready", m_ordy, 32'h7CE);

    // start held high throughout: ignored while busy, accepted in first IDLE after handshake
    run_seq(16'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h20, 9);
    chk("b2b.busy", m_busy, 32'h1BE);
    chk("b2b.op_ready", m_ordy, 32'h186);
    chk("b2b.out_valid", m_ov, 32'h30);
    chk("b2b.p_valid", m_pv, 32'h10C);
    chk("b2b.acc_int", m_acc, 32'h8);
    chk("b2b.term_idx_c7", 32'(ti_at[7]), 32'(0));

    for (int k = 0; k < 1500; k++) begin
      step($urandom_range(0, 5) == 0, CW'($urandom_range(0, 6)), $urandom_range(0, 3) != 0,
           $urandom_range(0, 99) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 299) == 0);
    end
    for (int k = 0; k < 20; k++) step(1'b0, '0, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("final.idle", 32'(o[6]), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/mac_job_sequencer.md
Name: mac_job_sequencer

Overview:
- Controller that sequences one super_mac array through a dot-product job of num_terms accumulation terms.
- Accepts a job via a start pulse and pulls operand pairs from the upstream feature/kernel fetch logic with a valid/ready handshake.
- Drives the array's global controls: input_valid, p_valid and accumulate_internal.
- Presents the finished result to the downstream writer with a valid/ready handshake and blocks the next job until the result is consumed.

Parameters:
- CNT_WIDTH, 16, width of num_terms and term_index; maximum job length is 2^CNT_WIDTH-1.
- P_DELAY, 1, cycles from mac_input_valid to the matching mac_p_valid (multiplier stage depth, range 1..4).
- ACC_DELAY, 1, cycles from the last mac_p_valid until the MAC outputs are stable (range 1..4).

Ports:
- clk  input  1  clock, all logic on rising edge
- arst_n_in  input  1  reset, synchronous, active-low
- start  input  1  job request; sampled only in IDLE
- num_terms  input  CNT_WIDTH  terms in the job; latched when start is accepted
- clear  input  1  synchronous flush/abort, highest priority after reset
- busy  output  1  high whenever state is not IDLE
- cfg_err  output  1  one-cycle pulse when start is rejected
- op_valid  input  1  upstream operand pair (a, b0..b15) valid
- op_ready  output  1  sequencer accepts operands this cycle
- term_index  output  CNT_WIDTH  index of the term being requested; used as the fetch address
- mac_input_valid  output  1  to super_mac input_valid
- mac_p_valid  output  1  to super_mac p_valid
- mac_accumulate_internal  output  1  to super_mac accumulate_internal
- out_valid  output  1  MAC outputs hold the final job result
- out_ready  input  1  downstream consumes the result

Behaviour:
- States: IDLE, RUN, DRAIN, RESULT.
- Reset (arst_n_in=0 at an edge):
  - state goes to IDLE; counters and delay lines are cleared.
  - busy, cfg_err, op_ready, mac_input_valid, mac_p_valid, mac_accumulate_internal and out_valid all read 0.
  - term_index resets to 0.
  - Reset mid-job discards the job.
- clear=1 at an edge has the same effect as reset. Any in-flight p_valid is suppressed and no out_valid is produced.
- IDLE:
  - start=1 with num_terms>0: latch num_terms, term_index<=0, go to RUN.
  - start=1 with num_terms==0: stay in IDLE; cfg_err=1 in the next cycle only.
  - start is ignored in every state other than IDLE.
- RUN:
  - op_ready=1 (registered, high for every RUN cycle).
  - fire = op_valid & op_ready. mac_input_valid = fire, combinational, so the array registers a/b in the same cycle.
  - On each fire term_index increments.
  - Fire with term_index==num_terms-1 goes to DRAIN. op_ready is 0 from the next cycle.
  - op_valid low stalls the job with no timeout; term_index holds.
- Control pipeline:
  - fire and a first flag (term_index==0) travel through a P_DELAY-deep shift register.
  - mac_p_valid = delayed fire.
  - mac_accumulate_internal = delayed fire & ~delayed first. It is 0 on the first product (load) and 1 on later products (add).
  - mac_accumulate_internal is forced to 0 whenever mac_p_valid=0.
- DRAIN:
  - A counter waits until the last mac_p_valid has issued, plus ACC_DELAY cycles.
  - If the last fire is in cycle t, out_valid is first high in cycle t+P_DELAY+ACC_DELAY. The state becomes RESULT then.
- RESULT:
  - out_valid=1, held until out_valid & out_ready.
  - On the handshake, go to IDLE in the next cycle, where busy=0 and out_valid=0.
  - out_ready while out_valid=0 is ignored.
- A new job can start no earlier than the first IDLE cycle after the result handshake. No overlap, so the accumulators are never clobbered before readout.
- term_index never wraps inside a job because num_terms ≤ 2^CNT_WIDTH-1.

Test Plan:
All scenarios use P_DELAY=1, ACC_DELAY=1; cycle 0 is the start cycle.
- Basic job: num_terms=3, op_valid constant 1.
  - op_ready is 1 in cycles 1-3; mac_input_valid is 1 in cycles 1-3; term_index reads 0,1,2.
  - mac_p_valid is 1 in cycles 2-4, with mac_accumulate_internal 0,1,1.
  - out_valid rises in cycle 5. With out_ready=1 in cycle 7, busy=0 in cycle 8.
- Bubbles: num_terms=3, op_valid low in cycles 2-3.
  - Fires occur in cycles 1, 4 and 5; mac_p_valid in cycles 2, 5 and 6.
  - out_valid rises in cycle 7; accumulate_internal pattern is 0,1,1.
- Single term: num_terms=1.
  - One mac_p_valid in cycle 2 with mac_accumulate_internal=0; out_valid in cycle 3.
- Rejected job: num_terms=0.
  - cfg_err=1 in cycle 1 only; busy stays 0; no MAC controls toggle.
- Abort: clear=1 in cycle 3 of a num_terms=5 job.
  - IDLE and busy=0 in cycle 4; mac_p_valid=0 from cycle 4; out_valid never asserts.
  - A new start in cycle 5 runs a clean job with the first accumulate_internal=0.
- Start while busy: start pulses during RUN and RESULT are ignored.
  - Back-to-back: start in the first IDLE cycle after the handshake gives op_ready high one cycle later and term_index=0.
